// File: rtl/fifo_pkg.sv
// Shared constants and the skid-buffer state type for the FIFO write-side control.
package fifo_pkg;

    localparam int DSIZE_DEF    = 8;
    localparam int ADDRSIZE_DEF = 4;

    // EMPTY: no word held; ONE: main register valid; TWO: main and skid both valid
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-code to binary conversion.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/wr_skid_ctrl.sv
// Write-side front end of an async FIFO: a 2-entry skid buffer that decouples
// upstream ready from wfull, plus a registered fill level and almost-full flag.
//
// state      | meaning
// SKID_EMPTY | nothing buffered, winc low
// SKID_ONE   | main register holds the oldest word
// SKID_TWO   | main holds oldest, skid holds next; upstream stalled
module wr_skid_ctrl
    import fifo_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int ADDRSIZE  = ADDRSIZE_DEF,
    parameter int AF_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DSIZE-1:0]    s_data,
    output logic                s_ready,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    skid_state_t      state_q, state_d;
    logic [DSIZE-1:0] main_q, skid_q;
    logic             ready_q;
    logic             main_valid, xfer, pop;
    logic             load_main, main_from_skid, load_skid;
    logic [PW-1:0]    wbin, rbin, level_d;

    assign main_valid = (state_q != SKID_EMPTY);
    assign winc       = main_valid & ~wfull;
    assign wdata      = main_q;
    assign s_ready    = ready_q;
    assign pop        = winc;
    assign xfer       = s_valid & ready_q;

    // State register and registered ready (ready never sees wfull combinationally)
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != SKID_TWO);
        end
    end

    // Next-state and data-register load decisions
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (xfer) begin
                    state_d   = SKID_ONE;
                    load_main = 1'b1;
                end
            end
            SKID_ONE: begin
                if (xfer && pop) begin
                    load_main = 1'b1;
                end else if (xfer) begin
                    state_d   = SKID_TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (pop) begin
                    state_d        = SKID_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // Data registers; contents are qualified by state so they need no reset
    always_ff @(posedge wclk) begin
        if (load_main) begin
            main_q <= main_from_skid ? skid_q : s_data;
        end
        if (load_skid) begin
            skid_q <= s_data;
        end
    end

    gray2bin #(.WIDTH(PW)) u_wptr_bin (
        .gray (wptr),
        .bin  (wbin)
    );

    gray2bin #(.WIDTH(PW)) u_rptr_bin (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // Modular subtraction handles pointer wrap; the synchronized read pointer
    // lags, so the level can only over-report occupancy.
    assign level_d = wbin - rbin;

    // Registered fill level and almost-full flag, updated together
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_d;
            walmost_full <= (level_d >= AF_LVL);
        end
    end

endmodule

// File: doc/wr_skid_ctrl.md
WR_SKID_CTRL -- requirements
Module: wr_skid_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 8, meaning data word width.
REQ-002 SHALL have parameter ADDRSIZE, default 4, meaning FIFO address width (depth 2^ADDRSIZE = 16).
REQ-003 SHALL have parameter AF_THRESH, default 12, meaning the fill level at or above which walmost_full asserts; legal range 1..2^ADDRSIZE.
REQ-004 wclk  input  1  write-domain clock; all logic on its rising edge.
REQ-005 wrst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_data  input  DSIZE  upstream word.
REQ-008 s_ready  output  1  upstream may transfer; a transfer occurs when s_valid & s_ready at a rising edge.
REQ-009 winc  output  1  FIFO write strobe.
REQ-010 wdata  output  DSIZE  FIFO write data.
REQ-011 wfull  input  1  registered FIFO-full flag from the write-pointer stage.
REQ-012 wptr  input  ADDRSIZE+1  Gray write pointer from the write-pointer stage.
REQ-013 wq2_rptr  input  ADDRSIZE+1  Gray read pointer already synchronized into wclk.
REQ-014 wlevel  output  ADDRSIZE+1  registered write-side fill level, range 0..2^ADDRSIZE.
REQ-015 walmost_full  output  1  registered almost-full flag.

Function
REQ-016 SHALL implement a 2-entry skid buffer (main and skid registers) with states EMPTY, ONE (main valid) and TWO (main and skid valid).
REQ-017 SHALL drive winc = main_valid & ~wfull combinationally and wdata = main register; a pop occurs when winc = 1.
REQ-018 SHALL drive s_ready from a flop loaded each cycle with (next_state != TWO), so there is no combinational path from wfull to s_ready.
REQ-019 EMPTY: transfer -> ONE with main <= s_data; otherwise stay.
REQ-020 ONE: transfer & pop -> ONE with main <= s_data; transfer & no pop -> TWO with skid <= s_data; pop only -> EMPTY; neither -> ONE.
REQ-021 TWO: pop -> ONE with main <= skid; otherwise stay; no transfer is possible because s_ready = 0.
REQ-022 SHALL preserve word order and SHALL NOT drop or duplicate any word, including on simultaneous transfer and pop.
REQ-023 SHALL hold wdata stable while winc is low and main_valid = 1 (wfull stall).
REQ-024 SHALL convert wptr and wq2_rptr from Gray to binary and register wlevel <= (wbin - rbin) mod 2^(ADDRSIZE+1) every cycle (1-cycle latency from pointer change).
REQ-025 SHALL register walmost_full <= (computed level >= AF_THRESH) in the same cycle as wlevel.
REQ-026 Pointer wrap-around: when the MSB of wptr differs from wq2_rptr, the modular subtraction SHALL still yield the correct level (e.g. wbin=1, rbin=17 -> 16).
REQ-027 The level SHALL be pessimistic (lags reads by the synchronizer delay) and never below the true occupancy.

Reset
REQ-028 On wrst_n low, asynchronously: state = EMPTY, main_valid = 0, s_ready = 0, wlevel = 0, walmost_full = 0; data registers need not be reset.
REQ-029 s_ready SHALL rise on the first wclk edge after wrst_n deasserts.
REQ-030 Reset mid-operation SHALL discard buffered words and deassert winc immediately.

Structure
REQ-031 Package fifo_pkg SHALL hold the default DSIZE/ADDRSIZE constants and the skid state enum typedef.
REQ-032 Sub-module gray2bin (parameter width ADDRSIZE+1) SHALL be instantiated twice, once for wptr and once for wq2_rptr.

Verification
REQ-033 Reset release, wfull = 0, s_valid high with words 0x01..0x10 -> s_ready = 1 after one edge, winc each cycle, wdata order 0x01..0x10, no gaps.
REQ-034 wfull = 1 while words 0xA0, 0xA1, 0xA2 are offered -> state TWO, s_ready = 0 after 2 transfers, wdata = 0xA0 held; wfull = 0 -> 0xA0, 0xA1, 0xA2 written in order.
REQ-035 Simultaneous transfer and pop in ONE for 20 cycles -> state stays ONE, throughput 1 word/cycle.
REQ-036 wptr = Gray(12), wq2_rptr = Gray(0) -> next cycle wlevel = 12, walmost_full = 1; wq2_rptr = Gray(1) -> wlevel = 11, walmost_full = 0.
REQ-037 Wrap: wptr = Gray(1), wq2_rptr = Gray(17) -> wlevel = 16; wptr = Gray(3), wq2_rptr = Gray(30) -> wlevel = 5.
REQ-038 wrst_n pulsed low in state TWO -> winc = 0, s_ready = 0, wlevel = 0 immediately; no stale word is written after release.
